abft_checksum_check: RTL

Checksum comparator sitting directly downstream of the four-stream checksum accumulator: it consumes the accumulated w/x/y/z checksums of each output tile (qualified by the accumulator's `valid_out`) and compares them with the predicted checksums produced upstream by the checksum predictor. Predicted values arrive earlier and on their own handshake, so they are buffered in a small FIFO and aligned in order with accumulator results. Per-tile mismatch flags, a fault state machine, a saturating error counter and protocol-error flags go to the fault-handling/status logic.

---
 rtl/abft_checksum_check.sv | 139 +++++++++++++
 1 files changed

// File: rtl/abft_checksum_check.sv
`default_nettype none
// ============================================================================
// abft_checksum_check : aligns predicted checksums (FIFO) with accumulated
// tile checksums, flags per-stream mismatches, tracks fault/error status.
// Revision: 1.0
// ============================================================================
module abft_checksum_check #(
   parameter int zBits         = 28,
   parameter int fifoDepth     = 4,
   parameter int fifoAddrWidth = 2,
   parameter int errCntBits    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  acc_valid,
   input  logic [zBits-1:0]      w_acc,
   input  logic [zBits-1:0]      x_acc,
   input  logic [zBits-1:0]      y_acc,
   input  logic [zBits-1:0]      z_acc,
   input  logic                  exp_valid,
   output logic                  exp_ready,
   input  logic [zBits-1:0]      w_exp,
   input  logic [zBits-1:0]      x_exp,
   input  logic [zBits-1:0]      y_exp,
   input  logic [zBits-1:0]      z_exp,
   input  logic                  err_clear,
   output logic                  check_valid,
   output logic [3:0]            mismatch,
   output logic                  fault,
   output logic [errCntBits-1:0] err_count,
   output logic                  underrun,
   output logic                  overrun
);

   typedef enum logic [0:0] {
      ST_OK    = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   localparam logic [fifoAddrWidth:0] DEPTH = (fifoAddrWidth+1)'(fifoDepth);

   logic [zBits-1:0]         w_mem [fifoDepth];
   logic [zBits-1:0]         x_mem [fifoDepth];
   logic [zBits-1:0]         y_mem [fifoDepth];
   logic [zBits-1:0]         z_mem [fifoDepth];
   logic [fifoAddrWidth-1:0] wr_ptr;
   logic [fifoAddrWidth-1:0] rd_ptr;
   logic [fifoAddrWidth:0]   count;
   state_t                   state;

   logic       push;
   logic       pop;
   logic       fifo_empty;
   logic       any_mis;
   logic [3:0] cmp;

   assign exp_ready  = (count != DEPTH);
   assign fifo_empty = (count == '0);
   assign push       = exp_valid && exp_ready;
   // No bypass: a set pushed this cycle is not visible to a same-cycle pop.
   assign pop        = acc_valid && !fifo_empty;

   assign cmp = {z_acc != z_mem[rd_ptr],
                 y_acc != y_mem[rd_ptr],
                 x_acc != x_mem[rd_ptr],
                 w_acc != w_mem[rd_ptr]};
   assign any_mis = pop && (cmp != 4'b0000);

   assign fault = (state == ST_FAULT);

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         w_mem[wr_ptr] <= w_exp;
         x_mem[wr_ptr] <= x_exp;
         y_mem[wr_ptr] <= y_exp;
         z_mem[wr_ptr] <= z_exp;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         check_valid <= 1'b0;
         mismatch    <= 4'b0000;
      end else begin
         check_valid <= pop;
         mismatch    <= pop ? cmp : 4'b0000;
      end
   end

   // Status: a new event in the same cycle as err_clear takes priority.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_OK;
         err_count <= '0;
         underrun  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            ST_OK:    if (any_mis) state <= ST_FAULT;
            ST_FAULT: if (!any_mis && err_clear) state <= ST_OK;
            default:  state <= ST_OK;
         endcase

         if (any_mis) begin
            if (err_clear)
               err_count <= {{(errCntBits-1){1'b0}}, 1'b1};
            else if (err_count != '1)
               err_count <= err_count + 1'b1;
         end else if (err_clear) begin
            err_count <= '0;
         end

         if (acc_valid && fifo_empty) underrun <= 1'b1;
         else if (err_clear)          underrun <= 1'b0;

         if (exp_valid && !exp_ready) overrun <= 1'b1;
         else if (err_clear)          overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire
